// File: rtl/memory_seq_gen.sv
// memory_seq_gen: seeds a 64-bit Galois LFSR from the game counter, fills a
// symbol buffer, then streams it out over valid/ready. Option: SEQ_GEN_NOREPEAT_EN.
module memory_seq_gen #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int SEED_W  = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [SEED_W-1:0] COUNT_VAL,
  input  logic              START,
  input  logic              REPLAY,
  input  logic [LEN_W-1:0]  LEVEL,
  input  logic              SYM_READY,
  output logic [1:0]        SYM,
  output logic              SYM_VALID,
  output logic              SEQ_DONE,
  output logic              BUSY,
  output logic [LEN_W-1:0]  SEQ_LEN,
  output logic [SEED_W-1:0] SEED_OUT
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [SEED_W-1:0] MASK = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, GEN, PLAY, DONE} state_t;

  state_t            state_q, state_d;
  logic [SEED_W-1:0] lfsr_q, lfsr_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [SEED_W-1:0] lfsr_s1, lfsr_s2, seed_new;
  logic [LEN_W-1:0]  len_q, len_d, lvl_clamp;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stored_q, stored_d;
  logic [1:0]        mem_q [MAX_LEN];
  logic              wr_en;
  logic [1:0]        wr_sym;
  logic              last, accept, valid;

  // LFSR two-step advance, length clamp and end-of-sequence detect
  always_comb begin
    lfsr_s1 = {1'b0, lfsr_q[SEED_W-1:1]} ^ (lfsr_q[0] ? MASK : '0);
    lfsr_s2 = {1'b0, lfsr_s1[SEED_W-1:1]} ^ (lfsr_s1[0] ? MASK : '0);
    seed_new = (COUNT_VAL == '0) ? SEED_W'(1) : COUNT_VAL;
    lvl_clamp = LEVEL;
    if (LEVEL == '0)
      lvl_clamp = LEN_W'(1);
    else if (LEVEL > LEN_W'(MAX_LEN))
      lvl_clamp = LEN_W'(MAX_LEN);
    last = (LEN_W'(idx_q) == len_q - LEN_W'(1));
    accept = valid & SYM_READY;
  end

  // Symbol to store; optionally bumped to avoid repeating the previous one
  always_comb begin
    wr_sym = lfsr_s2[1:0];
`ifdef SEQ_GEN_NOREPEAT_EN
    if (idx_q != '0 && lfsr_s2[1:0] == mem_q[idx_q - IDX_W'(1)])
      wr_sym = lfsr_s2[1:0] + 2'd1;
`endif
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (START)
          state_d = GEN;
        else if (REPLAY && stored_q)
          state_d = PLAY;
      end
      GEN:  if (last) state_d = PLAY;
      PLAY: if (accept && last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and buffer
  always_comb begin
    valid     = (state_q == PLAY);
    SYM_VALID = valid;
    SYM       = valid ? mem_q[idx_q] : 2'd0;
    SEQ_DONE  = (state_q == DONE);
    BUSY      = (state_q != IDLE);
    SEQ_LEN   = len_q;
    SEED_OUT  = seed_q;
  end

  // Datapath next values: seed, LFSR, length, index, stored flag
  always_comb begin
    lfsr_d   = lfsr_q;
    seed_d   = seed_q;
    len_d    = len_q;
    idx_d    = idx_q;
    stored_d = stored_q;
    wr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          seed_d   = seed_new;
          lfsr_d   = seed_new;
          len_d    = lvl_clamp;
          idx_d    = '0;
          stored_d = 1'b0;
        end else if (REPLAY && stored_q) begin
          idx_d = '0;
        end
      end
      GEN: begin
        lfsr_d = lfsr_s2;
        wr_en  = 1'b1;
        if (last) begin
          idx_d    = '0;
          stored_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      PLAY: begin
        if (accept)
          idx_d = last ? '0 : idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lfsr_q   <= '0;
      seed_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      stored_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      seed_q   <= seed_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      stored_q <= stored_d;
    end
  end

  // Symbol buffer; contents need no reset
  always_ff @(posedge CLK) begin
    if (wr_en)
      mem_q[idx_q] <= wr_sym;
  end

endmodule

// File: tb/tb_memory_seq_gen.sv
// tb_memory_seq_gen: directed checks of seeding, timing, clamp,
// backpressure, replay and reset abort for memory_seq_gen.
module tb_memory_seq_gen;

  localparam logic [63:0] MASK = 64'hD800_0000_0000_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [63:0] COUNT_VAL = '0;
  logic        START = 1'b0;
  logic        REPLAY = 1'b0;
  logic [4:0]  LEVEL = '0;
  logic        SYM_READY = 1'b0;
  logic [1:0]  SYM;
  logic        SYM_VALID, SEQ_DONE, BUSY;
  logic [4:0]  SEQ_LEN;
  logic [63:0] SEED_OUT;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_s [32];
  logic [1:0] got [32];
  int gotn;
  bit tmo;

  memory_seq_gen dut (
    .CLK(CLK), .RESET(RESET), .COUNT_VAL(COUNT_VAL), .START(START),
    .REPLAY(REPLAY), .LEVEL(LEVEL), .SYM_READY(SYM_READY), .SYM(SYM),
    .SYM_VALID(SYM_VALID), .SEQ_DONE(SEQ_DONE), .BUSY(BUSY),
    .SEQ_LEN(SEQ_LEN), .SEED_OUT(SEED_OUT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] step(input logic [63:0] x);
    return x[0] ? ((x >> 1) ^ MASK) : (x >> 1);
  endfunction

  task automatic model(input logic [63:0] seed, input int len);
    logic [63:0] x;
    logic [1:0] s;
    x = seed;
    for (int i = 0; i < len; i++) begin
      x = step(step(x));
      s = x[1:0];
`ifdef SEQ_GEN_NOREPEAT_EN
      if (i > 0 && s == exp_s[i-1]) s = s + 2'd1;
`endif
      exp_s[i] = s;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_seq(input logic [63:0] cv, input logic [4:0] lv);
    COUNT_VAL = cv;
    LEVEL = lv;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Drain with READY high, recording each valid symbol until SEQ_DONE
  task automatic collect();
    gotn = 0;
    tmo = 1'b1;
    SYM_READY = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (SEQ_DONE) begin
        tmo = 1'b0;
        break;
      end
      if (SYM_VALID && gotn < 32) begin
        got[gotn] = SYM;
        gotn++;
      end
      tick();
    end
    tick();
  endtask

  task automatic wait_valid();
    tmo = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (SYM_VALID) begin
        tmo = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({SYM, SYM_VALID, SEQ_DONE, BUSY, SEQ_LEN, SEED_OUT} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got sym=%0d v=%0b d=%0b b=%0b len=%0d seed=%h, want all 0",
               SYM, SYM_VALID, SEQ_DONE, BUSY, SEQ_LEN, SEED_OUT);
    end
    RESET = 1'b0;
    tick();
    REPLAY = 1'b1;
    tick();
    REPLAY = 1'b0;
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL replay_after_por: BUSY=%0b want 0", BUSY);
    end
  endtask

  task automatic test_zero_seed();
    start_seq(64'h0, 5'd4);
    model(64'h1, 4);
    n_cmp++;
    if (SEED_OUT !== 64'h1 || SEQ_LEN !== 5'd4) begin
      n_err++;
      $display("FAIL zero_seed: seed=%h len=%0d want 1 / 4", SEED_OUT, SEQ_LEN);
    end
    collect();
    n_cmp++;
    if (tmo || gotn != 4) begin
      n_err++;
      $display("FAIL zero_seed_count: got %0d tmo=%0b want 4", gotn, tmo);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== exp_s[i]) begin
        n_err++;
        $display("FAIL zero_seed_sym%0d: got %0d want %0d", i, got[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_timing();
    logic [7:0] v, b, d;
    logic [1:0] s [3];
    SYM_READY = 1'b1;
    model(64'h0123_4567_89AB_CDEF, 3);
    start_seq(64'h0123_4567_89AB_CDEF, 5'd3);
    v = '0; b = '0; d = '0;
    for (int t = 0; t < 8; t++) begin
      v[t] = SYM_VALID;
      b[t] = BUSY;
      d[t] = SEQ_DONE;
      if (t >= 3 && t <= 5) s[t-3] = SYM;
      tick();
    end
    n_cmp++;
    if (v !== 8'b0011_1000) begin
      n_err++;
      $display("FAIL timing_valid: got %b want 00111000", v);
    end
    n_cmp++;
    if (b !== 8'b1111_1111 - 8'b1000_0000) begin
      n_err++;
      $display("FAIL timing_busy: got %b want 01111111", b);
    end
    n_cmp++;
    if (d !== 8'b0100_0000) begin
      n_err++;
      $display("FAIL timing_done: got %b want 01000000", d);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (s[i] !== exp_s[i]) begin
        n_err++;
        $display("FAIL timing_sym%0d: got %0d want %0d", i, s[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_clamp();
    start_seq(64'hCAFE, 5'd0);
    model(64'hCAFE, 1);
    n_cmp++;
    if (SEQ_LEN !== 5'd1) begin
      n_err++;
      $display("FAIL clamp_lo_len: got %0d want 1", SEQ_LEN);
    end
    collect();
    n_cmp++;
    if (tmo || gotn != 1 || got[0] !== exp_s[0]) begin
      n_err++;
      $display("FAIL clamp_lo_syms: n=%0d s0=%0d want 1 / %0d", gotn, got[0], exp_s[0]);
    end
    start_seq(64'hDEAD_BEEF_0BAD_F00D, 5'd31);
    model(64'hDEAD_BEEF_0BAD_F00D, 16);
    n_cmp++;
    if (SEQ_LEN !== 5'd16) begin
      n_err++;
      $display("FAIL clamp_hi_len: got %0d want 16", SEQ_LEN);
    end
    collect();
    n_cmp++;
    if (tmo || gotn != 16) begin
      n_err++;
      $display("FAIL clamp_hi_count: got %0d want 16", gotn);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (got[i] !== exp_s[i]) begin
        n_err++;
        $display("FAIL clamp_hi_sym%0d: got %0d want %0d", i, got[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] s0;
    SYM_READY = 1'b0;
    model(64'h5555_0000_AAAA_1234, 6);
    start_seq(64'h5555_0000_AAAA_1234, 5'd6);
    wait_valid();
    s0 = SYM;
    n_cmp++;
    if (tmo || s0 !== exp_s[0]) begin
      n_err++;
      $display("FAIL bp_first: got %0d tmo=%0b want %0d", s0, tmo, exp_s[0]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (SYM_VALID !== 1'b1 || SYM !== exp_s[0]) begin
        n_err++;
        $display("FAIL bp_hold%0d: v=%0b sym=%0d want 1 / %0d", i, SYM_VALID, SYM, exp_s[0]);
      end
    end
    SYM_READY = 1'b1;
    tick();
    SYM_READY = 1'b0;
    n_cmp++;
    if (SYM_VALID !== 1'b1 || SYM !== exp_s[1]) begin
      n_err++;
      $display("FAIL bp_next: v=%0b sym=%0d want 1 / %0d", SYM_VALID, SYM, exp_s[1]);
    end
    collect();
    n_cmp++;
    if (tmo || gotn != 5 || got[4] !== exp_s[5]) begin
      n_err++;
      $display("FAIL bp_rest: n=%0d last=%0d want 5 / %0d", gotn, got[4], exp_s[5]);
    end
  endtask

  task automatic test_replay();
    logic [1:0] first [5];
    logic [63:0] sd;
    start_seq(64'h0F0F_1234_5678_9ABC, 5'd5);
    model(64'h0F0F_1234_5678_9ABC, 5);
    collect();
    for (int i = 0; i < 5; i++) first[i] = got[i];
    sd = SEED_OUT;
    REPLAY = 1'b1;
    tick();
    REPLAY = 1'b0;
    n_cmp++;
    if (SEED_OUT !== 64'h0F0F_1234_5678_9ABC || BUSY !== 1'b1) begin
      n_err++;
      $display("FAIL replay_seed: seed=%h busy=%0b want 0f0f123456789abc / 1", SEED_OUT, BUSY);
    end
    collect();
    n_cmp++;
    if (tmo || gotn != 5) begin
      n_err++;
      $display("FAIL replay_count: got %0d want 5", gotn);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got[i] !== exp_s[i] || first[i] !== exp_s[i]) begin
        n_err++;
        $display("FAIL replay_sym%0d: got %0d/%0d want %0d", i, first[i], got[i], exp_s[i]);
      end
    end
    n_cmp++;
    if (sd !== SEED_OUT) begin
      n_err++;
      $display("FAIL replay_seed_kept: got %h want %h", SEED_OUT, sd);
    end
    COUNT_VAL = 64'h7777_8888_9999_AAAA;
    LEVEL = 5'd2;
    START = 1'b1;
    REPLAY = 1'b1;
    tick();
    START = 1'b0;
    REPLAY = 1'b0;
    n_cmp++;
    if (SEED_OUT !== 64'h7777_8888_9999_AAAA || SYM_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL start_over_replay: seed=%h v=%0b want 777788889999aaaa / 0",
               SEED_OUT, SYM_VALID);
    end
    model(64'h7777_8888_9999_AAAA, 2);
    collect();
    n_cmp++;
    if (tmo || gotn != 2 || got[0] !== exp_s[0] || got[1] !== exp_s[1]) begin
      n_err++;
      $display("FAIL start_over_replay_syms: n=%0d s=%0d,%0d want 2 / %0d,%0d",
               gotn, got[0], got[1], exp_s[0], exp_s[1]);
    end
  endtask

  task automatic test_reset_mid_play();
    bit busy_seen;
    model(64'h1357_9BDF_2468_ACE0, 6);
    SYM_READY = 1'b0;
    start_seq(64'h1357_9BDF_2468_ACE0, 5'd6);
    wait_valid();
    SYM_READY = 1'b1;
    tick();
    tick();
    SYM_READY = 1'b0;
    n_cmp++;
    if (tmo || SYM !== exp_s[2] || SYM_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL mid_play_idx2: sym=%0d v=%0b want %0d / 1", SYM, SYM_VALID, exp_s[2]);
    end
    #2;
    RESET = 1'b1;
    #1;
    n_cmp++;
    if ({SYM, SYM_VALID, SEQ_DONE, BUSY, SEQ_LEN, SEED_OUT} !== '0) begin
      n_err++;
      $display("FAIL mid_play_reset: sym=%0d v=%0b d=%0b b=%0b len=%0d seed=%h want all 0",
               SYM, SYM_VALID, SEQ_DONE, BUSY, SEQ_LEN, SEED_OUT);
    end
    tick();
    RESET = 1'b0;
    tick();
    REPLAY = 1'b1;
    tick();
    REPLAY = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (BUSY || SYM_VALID) busy_seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (busy_seen !== 1'b0) begin
      n_err++;
      $display("FAIL replay_after_reset: busy/valid seen=%0b want 0", busy_seen);
    end
  endtask

`ifdef SEQ_GEN_NOREPEAT_EN
  task automatic test_norepeat();
    int bad;
    logic [63:0] sd;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      sd = {$urandom, $urandom};
      start_seq(sd, 5'd16);
      collect();
      if (tmo || gotn != 16) bad++;
      for (int i = 1; i < 16; i++)
        if (got[i] == got[i-1]) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL norepeat: %0d violations want 0", bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_seed();
    test_timing();
    test_clamp();
    test_backpressure();
    test_replay();
    test_reset_mid_play();
`ifdef SEQ_GEN_NOREPEAT_EN
    test_norepeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
